// File: rtl/int4_mac_pkg.sv
// rtl/int4_mac_pkg.sv - shared widths, latency and FSM state encoding for the int4 MAC feeder
package int4_mac_pkg;

  localparam int VEC_W   = 264;
  localparam int WORD_W  = 24;
  localparam int BEATS   = VEC_W / WORD_W;
  localparam int PSUM_W  = 24;
  localparam int MAC_LAT = 4;

  localparam int CNT_W = $clog2(BEATS);
  localparam int LAT_W = $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    ISSUE,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/int4_vec_assembler.sv
// rtl/int4_vec_assembler.sv - beat counter and insert register building the A and B vectors
module int4_vec_assembler
  import int4_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              sel_b,
  input  logic [WORD_W-1:0] data,
  output logic [VEC_W-1:0]  a_vec,
  output logic [VEC_W-1:0]  b_vec,
  output logic              first_beat,
  output logic              last_beat
);

  logic [CNT_W-1:0] cnt;

  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == CNT_W'(BEATS - 1));

  // One counter is shared by both vectors: A fills completely before B starts,
  // so the counter wraps to 0 between them. Beat k lands in bits [24k+23:24k].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_vec <= '0;
      b_vec <= '0;
    end else if (wr) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt == CNT_W'(k)) begin
          if (sel_b) b_vec[k*WORD_W +: WORD_W] <= data;
          else       a_vec[k*WORD_W +: WORD_W] <= data;
        end
      end
      cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/int4_mac_feeder.sv
// rtl/int4_mac_feeder.sv - sequences beat streams into int4_mac issues and chains tile accumulations
module int4_mac_feeder
  import int4_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic              mac_en,
  output logic [VEC_W-1:0]  mac_a_vec,
  output logic [VEC_W-1:0]  mac_b_vec,
  output logic [PSUM_W-1:0] mac_psum_in,
  input  logic [PSUM_W-1:0] mac_psum_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] out_sum
);

  state_t            state;
  logic [LAT_W-1:0]  lat;
  logic [PSUM_W-1:0] acc;
  logic              first_l;
  logic              last_l;
  logic              wr;
  logic              beat_first;
  logic              beat_last;

  assign wr      = in_valid && in_ready;
  assign out_sum = acc;

  int4_vec_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr),
    .sel_b      (state == LOAD_B),
    .data       (in_data),
    .a_vec      (mac_a_vec),
    .b_vec      (mac_b_vec),
    .first_beat (beat_first),
    .last_beat  (beat_last)
  );

  // Tile sequencer; handshake flags are registered alongside the state so
  // they switch on the same edge as the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_A;
      lat         <= '0;
      acc         <= '0;
      first_l     <= 1'b0;
      last_l      <= 1'b0;
      mac_psum_in <= '0;
      in_ready    <= 1'b1;
      mac_en      <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (wr) begin
            if (beat_first) begin
              first_l <= in_first;
              last_l  <= in_last;
            end
            if (beat_last) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (wr && beat_last) begin
            // A new accumulation drops whatever the previous tiles left in acc.
            mac_psum_in <= first_l ? '0 : acc;
            in_ready    <= 1'b0;
            mac_en      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          lat   <= LAT_W'(MAC_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (lat == '0) begin
            acc    <= mac_psum_out;
            mac_en <= 1'b0;
            if (last_l) begin
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              in_ready <= 1'b1;
              state    <= LOAD_A;
            end
          end else begin
            lat <= lat - 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD_A;
          end
        end
        default: begin
          state     <= LOAD_A;
          in_ready  <= 1'b1;
          mac_en    <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int4_mac_feeder.sv
// tb/tb_int4_mac_feeder.sv - directed self-checking bench for int4_mac_feeder
module tb_int4_mac_feeder;

  localparam int MAC_LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [23:0]  in_data;
  logic         in_first;
  logic         in_last;
  logic         mac_en;
  logic [263:0] mac_a_vec;
  logic [263:0] mac_b_vec;
  logic [23:0]  mac_psum_in;
  logic [23:0]  mac_psum_out;
  logic         out_valid;
  logic         out_ready;
  logic [23:0]  out_sum;

  int vecs = 0;
  int errs = 0;

  logic [23:0]  a_b [11];
  logic [23:0]  b_b [11];
  logic [263:0] exp_vec;
  logic         preset_en;
  logic [23:0]  preset_val;
  logic [23:0]  pipe [4];

  int4_mac_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_first     (in_first),
    .in_last      (in_last),
    .mac_en       (mac_en),
    .mac_a_vec    (mac_a_vec),
    .mac_b_vec    (mac_b_vec),
    .mac_psum_in  (mac_psum_in),
    .mac_psum_out (mac_psum_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dot(input logic [263:0] a, input logic [263:0] b);
    int s;
    logic signed [3:0] x;
    logic signed [3:0] y;
    s = 0;
    for (int i = 0; i < 66; i++) begin
      x = a[i*4 +: 4];
      y = b[i*4 +: 4];
      s += int'(x) * int'(y);
    end
    return s[23:0];
  endfunction

  // MAC stand-in: MAC_LAT-deep pipeline of psum_in + dot(a,b), or a preset value.
  always @(posedge clk) begin
    pipe[0] <= preset_en ? preset_val : mac_psum_in + dot(mac_a_vec, mac_b_vec);
    for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mac_psum_out = pipe[MAC_LAT-1];

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bufs(input logic [23:0] av, input logic [23:0] bv);
    for (int k = 0; k < 11; k++) begin
      a_b[k] = av;
      b_b[k] = bv;
    end
  endtask

  task automatic send_beat(input logic [23:0] d, input logic f, input logic l);
    int t;
    t = 0;
    in_data  = d;
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("beat_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_tile(input logic f, input logic l, input bit gap);
    for (int k = 0; k < 11; k++) begin
      if (gap) begin @(posedge clk); #1; end
      send_beat(a_b[k], (k == 0) ? f : 1'b0, (k == 0) ? l : 1'b0);
    end
    for (int k = 0; k < 11; k++) begin
      if (gap) begin @(posedge clk); #1; end
      send_beat(b_b[k], 1'b0, 1'b0);
    end
  endtask

  // Called just after the final B beat transfer edge: the DUT is in ISSUE.
  task automatic finish_tile(input string tag, input logic [23:0] exp_psum_in,
                             input logic exp_last, input logic [23:0] exp_sum);
    int  cyc;
    bit  saw_valid;
    chk({tag, "_issue_en"}, mac_en, 1'b1);
    chk({tag, "_psum_in"}, mac_psum_in, exp_psum_in);
    cyc = 1;
    saw_valid = 1'b0;
    if (exp_last) begin
      while (!out_valid && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk({tag, "_latency"}, cyc, 2 + MAC_LAT);
      chk({tag, "_sum"}, out_sum, exp_sum);
      chk({tag, "_out_in_ready"}, in_ready, 1'b0);
    end else begin
      while (!in_ready && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (out_valid) saw_valid = 1'b1;
      end
      chk({tag, "_no_out_valid"}, saw_valid, 1'b0);
      chk({tag, "_back_to_load"}, cyc, 2 + MAC_LAT);
    end
  endtask

  task automatic accept_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; preset_en = 1'b0; preset_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mac_en", mac_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 24'h0);
    chk("rst_psum_in", mac_psum_in, 24'h0);
    chk("rst_a_vec", mac_a_vec, 264'h0);
    rst_n = 1'b1;
    // out_ready with nothing pending must not disturb anything
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_ready_noeffect", out_valid, 1'b0);

    // single tile, 66 * (1*1)
    set_bufs(24'h111111, 24'h111111);
    send_tile(1'b1, 1'b1, 1'b0);
    finish_tile("single", 24'h0, 1'b1, 24'd66);
    accept_result("single");

    // signed tile, 66 * (1*-1)
    set_bufs(24'h111111, 24'hFFFFFF);
    send_tile(1'b1, 1'b1, 1'b0);
    finish_tile("signed", 24'h0, 1'b1, 24'hFFFFBE);
    accept_result("signed");

    // two-tile chain
    set_bufs(24'h111111, 24'h111111);
    send_tile(1'b1, 1'b0, 1'b0);
    finish_tile("chain1", 24'h0, 1'b0, 24'h0);
    send_tile(1'b0, 1'b1, 1'b0);
    finish_tile("chain2", 24'd66, 1'b1, 24'd132);
    accept_result("chain2");

    // first on a tile after a non-last tile restarts from zero
    send_tile(1'b1, 1'b0, 1'b0);
    finish_tile("restart1", 24'h0, 1'b0, 24'h0);
    send_tile(1'b1, 1'b1, 1'b0);
    finish_tile("restart2", 24'h0, 1'b1, 24'd66);
    accept_result("restart2");

    // gapped input and output backpressure; A beat k holds nibble k in every lane:
    // 6*(0+1+...+7) + 6*(-8-7-6) = 168 - 126 = 42
    for (int k = 0; k < 11; k++) begin
      a_b[k] = {6{4'(k)}};
      b_b[k] = 24'h111111;
      exp_vec[k*24 +: 24] = {6{4'(k)}};
    end
    send_tile(1'b1, 1'b1, 1'b1);
    chk("gap_a_vec", mac_a_vec, exp_vec);
    finish_tile("gap", 24'h0, 1'b1, 24'd42);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_sum", out_sum, 24'd42);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    chk("bp_a_vec_held", mac_a_vec, exp_vec);
    accept_result("bp");

    // reset after 5 A beats
    set_bufs(24'h111111, 24'h111111);
    for (int k = 0; k < 5; k++) send_beat(a_b[k], k == 0, k == 0);
    rst_n = 1'b0;
    #2;
    chk("midrst_mac_en", mac_en, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_sum", out_sum, 24'h0);
    chk("midrst_psum_in", mac_psum_in, 24'h0);
    chk("midrst_a_vec", mac_a_vec, 264'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_tile(1'b1, 1'b1, 1'b0);
    finish_tile("postrst", 24'h0, 1'b1, 24'd66);
    accept_result("postrst");

    // wrap-around: preset acc to FFFFF0, then add 66
    preset_en  = 1'b1;
    preset_val = 24'hFFFFF0;
    send_tile(1'b1, 1'b0, 1'b0);
    finish_tile("wrap1", 24'h0, 1'b0, 24'h0);
    preset_en = 1'b0;
    send_tile(1'b0, 1'b1, 1'b0);
    finish_tile("wrap2", 24'hFFFFF0, 1'b1, 24'h000032);
    accept_result("wrap2");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
